// File: rtl/moving_average_filter_mc.sv
// moving_average_filter_mc: multi-channel time-multiplexed boxcar moving average, window 2**LOG2_LEN.
// Optional macro MAF_ROUND_EN: round half toward +inf with saturation instead of floor division.
module moving_average_filter_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_LEN   = 9,
    parameter int NUM_CH     = 4,
    parameter int SIGNED     = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CH_W-1:0]       in_ch,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CH_W-1:0]       out_ch,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_primed
);
    localparam int L     = 1 << LOG2_LEN;
    localparam int SW    = DATA_WIDTH + LOG2_LEN;
    localparam int AW    = CH_W + LOG2_LEN;
    localparam int DEPTH = 1 << AW;
    localparam bit SGN   = SIGNED != 0;
    localparam logic [LOG2_LEN:0] FULL = (LOG2_LEN + 1)'(L);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [SW-1:0]         sum_q  [NUM_CH];
    logic [LOG2_LEN-1:0]   wptr_q [NUM_CH];
    logic [LOG2_LEN:0]     fill_q [NUM_CH];

    logic                  s1_valid_q;
    logic [CH_W-1:0]       s1_ch_q;
    logic [DATA_WIDTH-1:0] s1_data_q;
    logic [DATA_WIDTH-1:0] s1_old_q;
    logic [AW-1:0]         s1_addr_q;

    logic                  out_valid_q;
    logic [CH_W-1:0]       out_ch_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_primed_q;

    logic                  ch_ok, accept, fire, full;
    logic [AW-1:0]         rd_addr;
    logic [SW-1:0]         cur_sum, data_x, old_x, sum_d;
    logic [LOG2_LEN:0]     cur_fill, fill_d;
    logic [DATA_WIDTH-1:0] avg_d;

    assign in_ready = !(s1_valid_q && out_valid_q && !out_ready);
    assign ch_ok    = 32'(in_ch) < NUM_CH;
    assign accept   = in_valid && in_ready && ch_ok && !clear;
    assign fire     = s1_valid_q && (!out_valid_q || out_ready) && !clear;
    assign rd_addr  = {in_ch, wptr_q[in_ch]};

    // S1 arithmetic: the oldest sample only leaves the window once it is full
    always_comb begin
        cur_sum  = sum_q[s1_ch_q];
        cur_fill = fill_q[s1_ch_q];
        full     = cur_fill == FULL;
        data_x   = {{LOG2_LEN{SGN & s1_data_q[DATA_WIDTH-1]}}, s1_data_q};
        old_x    = {{LOG2_LEN{SGN & s1_old_q[DATA_WIDTH-1]}}, s1_old_q};
        sum_d    = cur_sum + data_x - (full ? old_x : '0);
        fill_d   = full ? cur_fill : cur_fill + 1'b1;
    end

`ifdef MAF_ROUND_EN
    logic [SW:0]         rnd;
    logic [DATA_WIDTH:0] rq;
    always_comb begin
        rnd   = {SGN & sum_d[SW-1], sum_d} + (SW + 1)'(1 << (LOG2_LEN - 1));
        rq    = rnd[SW:LOG2_LEN];
        avg_d = SGN ? ((rq[DATA_WIDTH] != rq[DATA_WIDTH-1]) ? {rq[DATA_WIDTH], {(DATA_WIDTH-1){!rq[DATA_WIDTH]}}}
                                                            : rq[DATA_WIDTH-1:0])
                    : (rq[DATA_WIDTH] ? '1 : rq[DATA_WIDTH-1:0]);
    end
`else
    assign avg_d = sum_d[SW-1:LOG2_LEN];
`endif

    // Sample RAM is deliberately not reset; fill gating hides stale contents
    always_ff @(posedge clk) begin
        if (accept)
            s1_old_q <= mem[rd_addr];
        if (fire)
            mem[s1_addr_q] <= s1_data_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c]  <= '0;
                wptr_q[c] <= '0;
                fill_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (clear) begin
                    sum_q[c]  <= '0;
                    wptr_q[c] <= '0;
                    fill_q[c] <= '0;
                end else begin
                    if (accept && in_ch == CH_W'(c))
                        wptr_q[c] <= wptr_q[c] + 1'b1;
                    if (fire && s1_ch_q == CH_W'(c)) begin
                        sum_q[c]  <= sum_d;
                        fill_q[c] <= fill_d;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_ch_q      <= '0;
            s1_data_q    <= '0;
            s1_addr_q    <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            out_data_q   <= '0;
            out_primed_q <= 1'b0;
        end else if (clear) begin
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid_q <= 1'b1;
                s1_ch_q    <= in_ch;
                s1_data_q  <= in_data;
                s1_addr_q  <= rd_addr;
            end else if (fire) begin
                s1_valid_q <= 1'b0;
            end
            if (fire) begin
                out_valid_q  <= 1'b1;
                out_ch_q     <= s1_ch_q;
                out_data_q   <= avg_d;
                out_primed_q <= fill_d == FULL;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign out_data   = out_data_q;
    assign out_primed = out_primed_q;
endmodule
